pi_alu_seq: RTL and testbench
=============================

Name: pi_alu_seq

Overview:
Control-side counterpart of the shared combinational ALU. It loads operands into the ALU's Accum/Pcomp inputs, drives the op-control lines (src1sel, src0sel, multiply, saturate, mult2, mult4, sub), and captures dst into internal state. Each go request runs a fixed four-op PI sequence (error, integrate, proportional multiply, sum) and produces one saturated 16-bit control result.

Parameters:
I_SHIFT, 0, integrator scaling on the SUM op: 0 = none, 1 = mult2, 2 = mult4 (3 is illegal and is flagged by an elaboration check).

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
go  in  1  start request; sampled only in IDLE
clr_intgrl  in  1  integrator clear; honoured only in IDLE
meas  in  16  measured value, signed
setpt  in  16  setpoint, signed
p_gain  in  16  proportional gain, signed
dst  in  16  ALU result (combinational from Accum/Pcomp/controls)
Accum  out  16  ALU operand A
Pcomp  out  16  ALU operand B
src1sel  out  3  constant SRC1_ACCUM
src0sel  out  3  constant SRC0_PCOMP
multiply  out  1  ALU multiply enable
saturate  out  1  ALU saturate enable
mult2  out  1  ALU x2 on src1
mult4  out  1  ALU x4 on src1
sub  out  1  ALU subtract
result  out  16  last completed PI output
busy  out  1  high from the cycle after go is accepted through the last EX
done  out  1  one-cycle pulse; result is valid on the same cycle

Behaviour:
- Reset: all outputs are 0 except src0sel = SRC0_PCOMP. Internal err_r, intgrl_r and pterm_r are 0. State is IDLE.
- FSM states: IDLE, LD_ERR, EX_ERR, LD_INT, EX_INT, LD_PM, EX_PM, LD_SUM, EX_SUM, FIN. Each state advances unconditionally except IDLE, which advances only when go = 1.
- LD_x state (registered outputs):
  - Accum and Pcomp are loaded with the operands for op x.
  - Control lines are set for op x.
  - The loaded values and controls are held unchanged through the following EX_x state.
- EX_x state: dst is captured at the end of EX_x.
- Op table (Accum, Pcomp, controls, capture target):
  - ERR: meas, setpt, sub=1 sat=1, err_r
  - INT: intgrl_r, err_r, sat=1, intgrl_r
  - PM: err_r, p_gain, multiply=1 sat=1, pterm_r
  - SUM: intgrl_r, pterm_r, sat=1 plus the mult2/mult4 bit selected by I_SHIFT, result
- In IDLE and FIN: multiply, saturate, mult2, mult4 and sub are 0. Accum and Pcomp hold their last values.
- Latency: go sampled high at edge k → LD_ERR at k+1 → done = 1 and result updated at edge k+9 (FIN). Return to IDLE at k+10.
- Back-to-back runs: go high in FIN is ignored. The next accepted go is at earliest in the first IDLE cycle.
- go while busy: ignored, not queued.
- clr_intgrl in IDLE: intgrl_r ← 0 at that edge.
  - If go is also high on the same edge, the run starts and LD_INT uses intgrl_r = 0.
  - clr_intgrl outside IDLE: ignored.
- rst mid-run: returns immediately to reset values. No done pulse. intgrl_r is cleared.
- The sequencer does no arithmetic; all width and saturation rules belong to the ALU.

Optional Feature:
ANTI_WINDUP_EN:
- Defined:
  - A sat_r flag is set when the captured SUM dst equals 16'h7FFF or 16'h8000, and cleared on any other SUM capture or on reset.
  - When sat_r = 1, the EX_INT capture is suppressed and intgrl_r holds.
  - Cycle count and ALU control sequence are unchanged.
- Undefined: intgrl_r always captures in EX_INT; no sat_r flop exists.

Decomposition:
- Shared package pi_alu_pkg:
  - SRC1_ACCUM = 3'd0, SRC0_PCOMP = 3'd3.
  - FSM state localparams (4-bit).
  - SAT_POS = 16'h7FFF, SAT_NEG = 16'h8000.
- Sub-module: none required. The op-table decode (state → Accum/Pcomp/control values) is natural as sub-module pi_alu_opdec (combinational) feeding the registered outputs.

Test Plan:
- Control sequence: rst, then go with meas=16'h0200, setpt=16'h0100; the bench drives dst from a script.
  - Required: cycle k+1 has Accum=0200, Pcomp=0100, sub=1, saturate=1, multiply=0.
  - Required: busy is high for 8 cycles and done is a single pulse at k+9.
- Writeback: script dst = 1111 (EX_ERR), 2222 (EX_INT), 3333 (EX_PM), 4444 (EX_SUM).
  - Required in LD_INT: Accum=0000, Pcomp=1111.
  - Required in LD_PM: Accum=1111, Pcomp=p_gain.
  - Required in LD_SUM: Accum=2222, Pcomp=3333.
  - Required at done: result=4444.
- I_SHIFT=2 build: in LD_SUM, mult4=1 and mult2=0; in all other states, mult4=0.
- Busy/clear handling:
  - Pulse go at k+3 → ignored, no second run.
  - Assert clr_intgrl together with go in IDLE → LD_INT shows Accum=0000.
- rst asserted in EX_PM → next cycle all outputs at reset values and intgrl_r = 0; no done pulse.
- ANTI_WINDUP_EN build: run 1 scripted SUM dst = 7FFF, run 2 scripted EX_INT dst = 5555 → run 2 LD_SUM shows Accum equal to the run-1 intgrl_r, not 5555.

Source files
------------

// File: rtl/pi_alu_pkg.sv
`default_nettype none
//============================================================================
// pi_alu_pkg : shared constants, state encoding and control struct for the
//              PI sequencer that drives the combinational ALU.
// Rev 1.0
//============================================================================
package pi_alu_pkg;

    localparam logic [2:0]  SRC1_ACCUM = 3'd0;
    localparam logic [2:0]  SRC0_PCOMP = 3'd3;

    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_LD_ERR = 4'd1;
    localparam logic [3:0] S_EX_ERR = 4'd2;
    localparam logic [3:0] S_LD_INT = 4'd3;
    localparam logic [3:0] S_EX_INT = 4'd4;
    localparam logic [3:0] S_LD_PM  = 4'd5;
    localparam logic [3:0] S_EX_PM  = 4'd6;
    localparam logic [3:0] S_LD_SUM = 4'd7;
    localparam logic [3:0] S_EX_SUM = 4'd8;
    localparam logic [3:0] S_FIN    = 4'd9;

    typedef enum logic [3:0] {
        ST_IDLE   = S_IDLE,
        ST_LD_ERR = S_LD_ERR,
        ST_EX_ERR = S_EX_ERR,
        ST_LD_INT = S_LD_INT,
        ST_EX_INT = S_EX_INT,
        ST_LD_PM  = S_LD_PM,
        ST_EX_PM  = S_EX_PM,
        ST_LD_SUM = S_LD_SUM,
        ST_EX_SUM = S_EX_SUM,
        ST_FIN    = S_FIN
    } state_t;

    typedef struct packed {
        logic multiply;
        logic saturate;
        logic mult2;
        logic mult4;
        logic sub;
    } alu_ctl_t;

    function automatic logic is_sat(input logic [15:0] val);
        return (val == SAT_POS) || (val == SAT_NEG);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pi_alu_seq_if.sv
`default_nettype none
//============================================================================
// pi_alu_seq_if : operand/control bus between the PI sequencer (master) and
//                 the shared combinational ALU (slave).
// Rev 1.0
//============================================================================
interface pi_alu_seq_if;

    logic [15:0] Accum;
    logic [15:0] Pcomp;
    logic [2:0]  src1sel;
    logic [2:0]  src0sel;
    logic        multiply;
    logic        saturate;
    logic        mult2;
    logic        mult4;
    logic        sub;
    logic [15:0] dst;

    modport master (
        output Accum, Pcomp, src1sel, src0sel,
        output multiply, saturate, mult2, mult4, sub,
        input  dst
    );

    modport slave (
        input  Accum, Pcomp, src1sel, src0sel,
        input  multiply, saturate, mult2, mult4, sub,
        output dst
    );

endinterface
`default_nettype wire

// File: rtl/pi_alu_opdec.sv
`default_nettype none
//============================================================================
// pi_alu_opdec : combinational op-table decode, state -> ALU operands and
//                control lines. load is high only in the LD_x states.
// Rev 1.0
//============================================================================
module pi_alu_opdec
    import pi_alu_pkg::*;
#(
    parameter int I_SHIFT = 0
) (
    input  state_t      state,
    input  logic [15:0] meas,
    input  logic [15:0] setpt,
    input  logic [15:0] p_gain,
    input  logic [15:0] err_v,
    input  logic [15:0] intgrl_v,
    input  logic [15:0] pterm_v,
    output logic        load,
    output logic [15:0] accum,
    output logic [15:0] pcomp,
    output alu_ctl_t    ctl
);

    always_comb begin
        load  = 1'b0;
        accum = '0;
        pcomp = '0;
        ctl   = '0;
        case (state)
            ST_LD_ERR, ST_EX_ERR: begin
                load         = (state == ST_LD_ERR);
                accum        = meas;
                pcomp        = setpt;
                ctl.sub      = 1'b1;
                ctl.saturate = 1'b1;
            end
            ST_LD_INT, ST_EX_INT: begin
                load         = (state == ST_LD_INT);
                accum        = intgrl_v;
                pcomp        = err_v;
                ctl.saturate = 1'b1;
            end
            ST_LD_PM, ST_EX_PM: begin
                load         = (state == ST_LD_PM);
                accum        = err_v;
                pcomp        = p_gain;
                ctl.multiply = 1'b1;
                ctl.saturate = 1'b1;
            end
            ST_LD_SUM, ST_EX_SUM: begin
                load         = (state == ST_LD_SUM);
                accum        = intgrl_v;
                pcomp        = pterm_v;
                ctl.saturate = 1'b1;
                ctl.mult2    = (I_SHIFT == 1);
                ctl.mult4    = (I_SHIFT == 2);
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pi_alu_seq.sv
`default_nettype none
//============================================================================
// pi_alu_seq : sequences one PI computation (error, integrate, P multiply,
//              sum) through the shared ALU per go. Option: ANTI_WINDUP_EN.
// Rev 1.0
//============================================================================
module pi_alu_seq
    import pi_alu_pkg::*;
#(
    parameter int I_SHIFT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic          clr_intgrl,
    input  logic [15:0]   meas,
    input  logic [15:0]   setpt,
    input  logic [15:0]   p_gain,
    pi_alu_seq_if.master  alu,
    output logic [15:0]   result,
    output logic          busy,
    output logic          done
);

    generate
        if (I_SHIFT < 0 || I_SHIFT > 2) begin : g_bad_i_shift
            $error("pi_alu_seq: I_SHIFT must be 0, 1 or 2");
        end
    endgenerate

    state_t      state_r;
    state_t      state_nxt;
    logic [15:0] err_r;
    logic [15:0] intgrl_r;
    logic [15:0] pterm_r;
    logic [15:0] result_r;
    logic [15:0] accum_r;
    logic [15:0] pcomp_r;
    alu_ctl_t    ctl_r;

    logic [15:0] err_nxt;
    logic [15:0] intgrl_nxt;
    logic [15:0] pterm_nxt;
    logic        int_cap;
    logic        dec_load;
    logic [15:0] dec_accum;
    logic [15:0] dec_pcomp;
    alu_ctl_t    dec_ctl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_IDLE:   state_nxt = go ? ST_LD_ERR : ST_IDLE;
            ST_LD_ERR: state_nxt = ST_EX_ERR;
            ST_EX_ERR: state_nxt = ST_LD_INT;
            ST_LD_INT: state_nxt = ST_EX_INT;
            ST_EX_INT: state_nxt = ST_LD_PM;
            ST_LD_PM:  state_nxt = ST_EX_PM;
            ST_EX_PM:  state_nxt = ST_LD_SUM;
            ST_LD_SUM: state_nxt = ST_EX_SUM;
            ST_EX_SUM: state_nxt = ST_FIN;
            ST_FIN:    state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

`ifdef ANTI_WINDUP_EN
    logic sat_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_r <= 1'b0;
        end else if (state_r == ST_EX_SUM) begin
            sat_r <= is_sat(alu.dst);
        end
    end

    assign int_cap = (state_r == ST_EX_INT) && !sat_r;
`else
    assign int_cap = (state_r == ST_EX_INT);
`endif

    // Captured values are forwarded so an LD_x loading on the same edge as
    // the preceding EX_x capture sees the fresh dst, not the stale register.
    assign err_nxt    = (state_r == ST_EX_ERR) ? alu.dst : err_r;
    assign pterm_nxt  = (state_r == ST_EX_PM)  ? alu.dst : pterm_r;
    assign intgrl_nxt = ((state_r == ST_IDLE) && clr_intgrl) ? 16'h0000 :
                        int_cap                               ? alu.dst  :
                                                                intgrl_r;

    pi_alu_opdec #(
        .I_SHIFT  (I_SHIFT)
    ) u_opdec (
        .state    (state_nxt),
        .meas     (meas),
        .setpt    (setpt),
        .p_gain   (p_gain),
        .err_v    (err_nxt),
        .intgrl_v (intgrl_nxt),
        .pterm_v  (pterm_nxt),
        .load     (dec_load),
        .accum    (dec_accum),
        .pcomp    (dec_pcomp),
        .ctl      (dec_ctl)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            err_r    <= '0;
            intgrl_r <= '0;
            pterm_r  <= '0;
            result_r <= '0;
            accum_r  <= '0;
            pcomp_r  <= '0;
            ctl_r    <= '0;
        end else begin
            err_r    <= err_nxt;
            intgrl_r <= intgrl_nxt;
            pterm_r  <= pterm_nxt;
            ctl_r    <= dec_ctl;
            if (dec_load) begin
                accum_r <= dec_accum;
                pcomp_r <= dec_pcomp;
            end
            if (state_r == ST_EX_SUM) begin
                result_r <= alu.dst;
            end
        end
    end

    assign alu.Accum    = accum_r;
    assign alu.Pcomp    = pcomp_r;
    assign alu.src1sel  = SRC1_ACCUM;
    assign alu.src0sel  = SRC0_PCOMP;
    assign alu.multiply = ctl_r.multiply;
    assign alu.saturate = ctl_r.saturate;
    assign alu.mult2    = ctl_r.mult2;
    assign alu.mult4    = ctl_r.mult4;
    assign alu.sub      = ctl_r.sub;

    assign result = result_r;
    assign busy   = (state_r != ST_IDLE) && (state_r != ST_FIN);
    assign done   = (state_r == ST_FIN);

endmodule
`default_nettype wire

// File: tb/tb_pi_alu_seq.sv
`default_nettype none
//============================================================================
// tb_pi_alu_seq : randomized self-checking bench; plays the ALU by scripting
//                 dst and compares against an op-level PI sequence model.
// Rev 1.0
//============================================================================
module tb_pi_alu_seq;

    localparam int TB_I_SHIFT = 2;
`ifdef ANTI_WINDUP_EN
    localparam bit AW = 1'b1;
`else
    localparam bit AW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic        clr_intgrl;
    logic [15:0] meas;
    logic [15:0] setpt;
    logic [15:0] p_gain;
    logic [15:0] result;
    logic        busy;
    logic        done;

    pi_alu_seq_if alu_if ();

    pi_alu_seq #(
        .I_SHIFT    (TB_I_SHIFT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .go         (go),
        .clr_intgrl (clr_intgrl),
        .meas       (meas),
        .setpt      (setpt),
        .p_gain     (p_gain),
        .alu        (alu_if.master),
        .result     (result),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int run_no  = 0;

    // Reference state: what the sequencer should remember between ops.
    logic [15:0] m_err, m_int, m_pterm, m_result, m_acc, m_pc;
    bit          m_sat;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_err = '0; m_int = '0; m_pterm = '0; m_result = '0;
        m_acc = '0; m_pc = '0; m_sat = 1'b0;
    endtask

    task automatic check_outputs(input string ph, input logic [4:0] ectl,
                                 input bit ebusy, input bit edone);
        check_eq({ph, " Accum"},  alu_if.Accum, m_acc);
        check_eq({ph, " Pcomp"},  alu_if.Pcomp, m_pc);
        check_eq({ph, " ctl"},    16'({alu_if.multiply, alu_if.saturate, alu_if.mult2,
                                       alu_if.mult4, alu_if.sub}), 16'(ectl));
        check_eq({ph, " busy"},   16'(busy), 16'(ebusy));
        check_eq({ph, " done"},   16'(done), 16'(edone));
        check_eq({ph, " result"}, result, m_result);
        check_eq({ph, " srcsel"}, 16'({alu_if.src1sel, alu_if.src0sel}), 16'h0003);
    endtask

    task automatic mid_reset();
        rst = 1'b1; go = 1'b0; clr_intgrl = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_outputs($sformatf("run%0d rst", run_no), 5'b00000, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_outputs($sformatf("run%0d post_rst", run_no), 5'b00000, 1'b0, 1'b0);
    endtask

    // One go request; cycle j (1..10) is the j-th cycle after go is taken.
    // The ALU result for op x is whatever dst holds during its EX cycle.
    task automatic run_pi(input logic [15:0] ms, input logic [15:0] sp, input logic [15:0] pg,
                          input bit clr, input logic [15:0] de, input logic [15:0] di,
                          input logic [15:0] dp, input logic [15:0] ds,
                          input bit noise, input int rst_at);
        logic [4:0] ectl;
        run_no++;
        meas = ms; setpt = sp; p_gain = pg; clr_intgrl = clr; go = 1'b1;
        @(posedge clk); #1;
        if (clr) m_int = '0;
        ectl = '0;
        for (int j = 1; j <= 10; j++) begin
            case (j)
                1: begin m_acc = ms;    m_pc = sp;      ectl = 5'b01001; end
                3: begin m_acc = m_int; m_pc = m_err;   ectl = 5'b01000; end
                5: begin m_acc = m_err; m_pc = pg;      ectl = 5'b11000; end
                7: begin m_acc = m_int; m_pc = m_pterm;
                         ectl = {1'b0, 1'b1, TB_I_SHIFT == 1, TB_I_SHIFT == 2, 1'b0}; end
                9, 10: ectl = 5'b00000;
                default: ;
            endcase
            check_outputs($sformatf("run%0d c%0d", run_no, j), ectl, j <= 8, j == 9);
            if (j == rst_at) begin
                mid_reset();
                return;
            end
            if (j == 10) begin
                go = 1'b0; clr_intgrl = 1'b0;
                break;
            end
            meas  = 16'($urandom);
            setpt = 16'($urandom);
            if (j >= 5) p_gain = 16'($urandom);
            go         = noise ? 1'($urandom_range(0, 1)) : (j == 2);
            clr_intgrl = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            case (j)
                2: begin alu_if.dst = de; m_err = de; end
                4: begin alu_if.dst = di; if (!(AW && m_sat)) m_int = di; end
                6: begin alu_if.dst = dp; m_pterm = dp; end
                8: begin alu_if.dst = ds; m_result = ds;
                         m_sat = AW && (ds == 16'h7FFF || ds == 16'h8000); end
                default: alu_if.dst = 16'($urandom);
            endcase
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] ds;
        rst = 1'b1; go = 1'b0; clr_intgrl = 1'b0;
        meas = '0; setpt = '0; p_gain = '0; alu_if.dst = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("in_reset", 5'b00000, 1'b0, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_outputs("idle", 5'b00000, 1'b0, 1'b0);

        // Scripted writeback run, with a stray go pulse mid-run.
        run_pi(16'h0200, 16'h0100, 16'h0040, 1'b0,
               16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0, 0);
        // clr_intgrl together with go: LD_INT must see a zero integrator.
        run_pi(16'h1234, 16'h0FF0, 16'h0101, 1'b1,
               16'hAAAA, 16'h5A5A, 16'h0F0F, 16'h1357, 1'b0, 0);
        // Reset during EX_PM, then a run showing the cleared integrator.
        run_pi(16'h0300, 16'h0010, 16'h0002, 1'b0,
               16'h0123, 16'h0456, 16'h0789, 16'h0ABC, 1'b0, 6);
        run_pi(16'h0007, 16'h0003, 16'h0005, 1'b0,
               16'h0004, 16'h6666, 16'h0014, 16'h7FFF, 1'b0, 0);
        // Saturated SUM above, then an integrate whose capture may be held.
        run_pi(16'h0008, 16'h0001, 16'h0003, 1'b0,
               16'h0007, 16'h5555, 16'h0015, 16'h1000, 1'b0, 0);

        for (int r = 0; r < 40; r++) begin
            ds = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 16'h7FFF : 16'h8000)
                                             : 16'($urandom);
            run_pi(16'($urandom), 16'($urandom), 16'($urandom),
                   ($urandom_range(0, 3) == 0),
                   16'($urandom), 16'($urandom), 16'($urandom), ds, 1'b1,
                   ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 8)) : 0);
        end

        go = 1'b0; clr_intgrl = 1'b0;
        @(posedge clk); #1;
        check_outputs("final_idle", 5'b00000, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
